// File: rtl/jtag_tap_driver.sv
// ============================================================================
// Module   : jtag_tap_driver
// Brief    : Host-side JTAG master: resets the TAP, loads an instruction,
//            optionally shifts a data register and returns captured TDO bits.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module jtag_tap_driver #(
  parameter int IR_WIDTH = 4,
  parameter int DR_WIDTH = 32,
  parameter int CLK_DIV  = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          START,
  input  logic [IR_WIDTH-1:0]           IR_VALUE,
  input  logic [DR_WIDTH-1:0]           DR_IN,
  input  logic [$clog2(DR_WIDTH+1)-1:0] DR_LEN,
  input  logic                          TDO,
  output logic                          TCK,
  output logic                          TMS,
  output logic                          TDI,
  output logic                          READY,
  output logic                          DONE,
  output logic [IR_WIDTH-1:0]           IR_OUT,
  output logic [DR_WIDTH-1:0]           DR_OUT
);

  localparam int LW = $clog2(DR_WIDTH + 1);
  localparam int SW = $clog2(DR_WIDTH + IR_WIDTH + 8);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] c_DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [LW-1:0] c_DR_MAX   = LW'(DR_WIDTH);

  localparam logic [3:0] S_RESET_SEQ = 4'd0;
  localparam logic [3:0] S_IDLE      = 4'd1;
  localparam logic [3:0] S_IR_HEAD   = 4'd2;
  localparam logic [3:0] S_IR_SHIFT  = 4'd3;
  localparam logic [3:0] S_IR_TAIL   = 4'd4;
  localparam logic [3:0] S_DR_HEAD   = 4'd5;
  localparam logic [3:0] S_DR_SHIFT  = 4'd6;
  localparam logic [3:0] S_DR_TAIL   = 4'd7;
  localparam logic [3:0] S_FINISH    = 4'd8;

  logic [3:0]          r_state;
  logic [SW-1:0]       r_step;
  logic                r_phase;
  logic [CW-1:0]       r_cnt;
  logic [IR_WIDTH-1:0] r_ir_sh;
  logic [DR_WIDTH-1:0] r_dr_sh;
  logic [LW-1:0]       r_dr_len;
  logic                r_tck;
  logic                r_tms;
  logic                r_tdi;
  logic                r_ready;
  logic                r_done;
  logic [IR_WIDTH-1:0] r_ir_out;
  logic [DR_WIDTH-1:0] r_dr_out;

  logic [3:0]          w_state_nxt;
  logic                w_accept;
  logic                w_stepping;
  logic                w_phase_end;
  logic                w_step_end;
  logic [SW-1:0]       w_nsteps;
  logic                w_last;
  logic                w_tck;
  logic                w_tms;
  logic                w_tdi;
  logic                w_rise;

  assign w_accept    = START & r_ready;
  assign w_stepping  = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign w_phase_end = w_stepping && (r_cnt == c_DIV_LAST);
  assign w_step_end  = w_phase_end & r_phase;
  assign w_last      = (r_step == w_nsteps - SW'(1));
  assign w_rise      = w_tck & ~r_tck;

  always_comb begin
    w_nsteps = SW'(1);
    case (r_state)
      S_RESET_SEQ: w_nsteps = SW'(6);
      S_IR_HEAD:   w_nsteps = SW'(4);
      S_IR_SHIFT:  w_nsteps = SW'(IR_WIDTH);
      S_IR_TAIL:   w_nsteps = SW'(2);
      S_DR_HEAD:   w_nsteps = SW'(3);
      S_DR_SHIFT:  w_nsteps = SW'(r_dr_len);
      S_DR_TAIL:   w_nsteps = SW'(2);
      default:     w_nsteps = SW'(1);
    endcase
  end

  // State register plus the TCK phase/step sequencer that belongs to it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_RESET_SEQ;
      r_step  <= '0;
      r_phase <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || !w_stepping) begin
        r_step  <= '0;
        r_phase <= 1'b0;
        r_cnt   <= '0;
      end else if (w_phase_end) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
        if (r_phase) r_step <= r_step + SW'(1);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RESET_SEQ: if (w_step_end && w_last) w_state_nxt = S_IDLE;
      S_IDLE:      if (w_accept) w_state_nxt = S_IR_HEAD;
      S_IR_HEAD:   if (w_step_end && w_last) w_state_nxt = S_IR_SHIFT;
      S_IR_SHIFT:  if (w_step_end && w_last) w_state_nxt = S_IR_TAIL;
      S_IR_TAIL:   if (w_step_end && w_last)
                     w_state_nxt = (r_dr_len == '0) ? S_FINISH : S_DR_HEAD;
      S_DR_HEAD:   if (w_step_end && w_last) w_state_nxt = S_DR_SHIFT;
      S_DR_SHIFT:  if (w_step_end && w_last) w_state_nxt = S_DR_TAIL;
      S_DR_TAIL:   if (w_step_end && w_last) w_state_nxt = S_FINISH;
      S_FINISH:    w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_RESET_SEQ;
    endcase
  end

  always_comb begin
    w_tck = w_stepping & r_phase;
    w_tms = 1'b0;
    w_tdi = 1'b0;
    case (r_state)
      S_RESET_SEQ: w_tms = (r_step < SW'(5));
      S_IR_HEAD:   w_tms = (r_step < SW'(2));
      S_IR_SHIFT:  begin w_tms = w_last; w_tdi = r_ir_sh[0]; end
      S_IR_TAIL:   w_tms = (r_step == '0);
      S_DR_HEAD:   w_tms = (r_step == '0);
      S_DR_SHIFT:  begin w_tms = w_last; w_tdi = r_dr_sh[0]; end
      S_DR_TAIL:   w_tms = (r_step == '0);
      default:     w_tms = 1'b0;
    endcase
  end

  // Pins lag the sequencer by one CLK so every pin comes straight from a flop;
  // TDO is taken on the same edge that raises TCK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tck    <= 1'b0;
      r_tms    <= 1'b1;
      r_tdi    <= 1'b0;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_ir_sh  <= '0;
      r_dr_sh  <= '0;
      r_dr_len <= '0;
      r_ir_out <= '0;
      r_dr_out <= '0;
    end else begin
      r_tck   <= w_tck;
      r_tms   <= w_tms;
      r_tdi   <= w_tdi;
      r_done  <= (r_state == S_FINISH);
      r_ready <= (r_state == S_IDLE) & ~w_accept;
      if (w_accept) begin
        r_ir_sh  <= IR_VALUE;
        r_dr_sh  <= DR_IN;
        r_dr_len <= (DR_LEN > c_DR_MAX) ? c_DR_MAX : DR_LEN;
        r_ir_out <= '0;
        r_dr_out <= '0;
      end else begin
        if (w_step_end && (r_state == S_IR_SHIFT)) r_ir_sh <= r_ir_sh >> 1;
        if (w_step_end && (r_state == S_DR_SHIFT)) r_dr_sh <= r_dr_sh >> 1;
        if (w_rise && (r_state == S_IR_SHIFT))
          r_ir_out <= r_ir_out | (IR_WIDTH'(TDO) << r_step);
        if (w_rise && (r_state == S_DR_SHIFT))
          r_dr_out <= r_dr_out | (DR_WIDTH'(TDO) << r_step);
      end
    end
  end

  assign TCK    = r_tck;
  assign TMS    = r_tms;
  assign TDI    = r_tdi;
  assign READY  = r_ready;
  assign DONE   = r_done;
  assign IR_OUT = r_ir_out;
  assign DR_OUT = r_dr_out;

endmodule

`default_nettype wire

// File: tb/tb_jtag_tap_driver.sv
// ============================================================================
// Module   : tb_jtag_tap_driver
// Brief    : Scoreboard bench for jtag_tap_driver with a behavioural TAP target.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_jtag_tap_driver;

  localparam logic [31:0] IDCODE = 32'h1234_5677;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start3 = 1'b0;
  logic [3:0]  ir_value = '0;
  logic [31:0] dr_in = '0;
  logic [5:0]  dr_len = '0;
  logic        tdo = 1'b0, tdo3 = 1'b0;
  logic        tck, tms, tdi, ready, done;
  logic [3:0]  ir_out;
  logic [31:0] dr_out;
  logic        tck3, tms3, tdi3, ready3, done3;
  logic [3:0]  ir_out3;
  logic [31:0] dr_out3;

  always #5 clk = ~clk;

  jtag_tap_driver #(.IR_WIDTH(4), .DR_WIDTH(32), .CLK_DIV(1)) u_dut (
    .CLK(clk), .RST(rst), .START(start), .IR_VALUE(ir_value), .DR_IN(dr_in),
    .DR_LEN(dr_len), .TDO(tdo), .TCK(tck), .TMS(tms), .TDI(tdi), .READY(ready),
    .DONE(done), .IR_OUT(ir_out), .DR_OUT(dr_out));

  jtag_tap_driver #(.IR_WIDTH(4), .DR_WIDTH(32), .CLK_DIV(3)) u_dut3 (
    .CLK(clk), .RST(rst), .START(start3), .IR_VALUE(ir_value), .DR_IN(dr_in),
    .DR_LEN(dr_len), .TDO(tdo3), .TCK(tck3), .TMS(tms3), .TDI(tdi3), .READY(ready3),
    .DONE(done3), .IR_OUT(ir_out3), .DR_OUT(dr_out3));

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural TAP target: 16-state controller, IDCODE/bypass data registers.
  localparam logic [3:0] TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
    PSDR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12,
    PSIR = 13, EX2IR = 14, UPIR = 15;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PSDR;
      PSDR:    return m ? EX2DR : PSDR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PSIR;
      PSIR:    return m ? EX2IR : PSIR;
      EX2IR:   return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  logic [3:0]  tap_st = TLR;
  logic [3:0]  tap_ir = 4'h7;
  logic [3:0]  ir_sr = '0;
  logic [31:0] dr_sr = '0;
  int          rises = 0;
  int          shdr_steps = 0;
  logic        shdr_last_tms = 1'b0;
  logic [5:0]  tms_log = '0;
  int          tms_n = 0;

  always @(posedge tck) begin
    rises++;
    if (tms_n < 6) tms_log[tms_n] = tms;
    tms_n++;
    case (tap_st)
      CAPIR: ir_sr = 4'b0001;
      SHIR:  ir_sr = {tdi, ir_sr[3:1]};
      UPIR:  tap_ir = ir_sr;
      CAPDR: dr_sr = (tap_ir == 4'h7) ? IDCODE : 32'h0;
      SHDR: begin
        shdr_steps++;
        shdr_last_tms = tms;
        dr_sr = (tap_ir == 4'h7) ? {tdi, dr_sr[31:1]} : {31'h0, tdi};
      end
      TLR:   tap_ir = 4'h7;
      default: ;
    endcase
    tap_st = tap_next(tap_st, tms);
  end

  always @(negedge tck)
    tdo = (tap_st == SHIR) ? ir_sr[0] : (tap_st == SHDR) ? dr_sr[0] : 1'b0;

  // Scoreboard: stimulus pushes, this monitor pops on every DONE.
  typedef struct {
    string       nm;
    logic [3:0]  ir;
    logic [31:0] dr;
    int          per;
    int          base;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   done_cnt = 0;

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got DONE=1 required no DONE");
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.nm, "_ir_out"}, 64'(ir_out), 64'(mon_e.ir));
        check({mon_e.nm, "_dr_out"}, 64'(dr_out), 64'(mon_e.dr));
        check({mon_e.nm, "_tck_periods"}, 64'(rises - mon_e.base), 64'(mon_e.per));
        check({mon_e.nm, "_ready_at_done"}, 64'(ready), 64'd0);
      end
    end
  end

  // TCK phase-length monitor for the divided instance.
  int   rises3 = 0, done3_cnt = 0, run3 = 0;
  logic prev3 = 1'b0;
  bit   meas3 = 1'b0, seen_fall3 = 1'b0;
  int   hmin = 99, hmax = 0, lmin = 99, lmax = 0;

  always @(posedge tck3) rises3++;

  always @(negedge clk) begin
    if (done3) done3_cnt++;
    if (tck3 === prev3) run3++;
    else begin
      if (meas3) begin
        if (prev3) begin
          if (run3 < hmin) hmin = run3;
          if (run3 > hmax) hmax = run3;
          seen_fall3 = 1'b1;
        end else if (seen_fall3) begin
          if (run3 < lmin) lmin = run3;
          if (run3 > lmax) lmax = run3;
        end
      end
      prev3 = tck3;
      run3 = 1;
    end
  end

  task automatic wait_ready(input string nm, input int maxc);
    int n = 0;
    while (!ready && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL %s: READY still 0 after %0d cycles, required 1", nm, maxc);
    end
  endtask

  task automatic txn(input string nm, input logic [3:0] ir, input logic [31:0] din,
                     input logic [5:0] len, input logic [3:0] eir, input logic [31:0] edr,
                     input int per);
    exp_t e;
    int n = 0;
    wait_ready({nm, "_ready"}, 400);
    @(posedge clk); #1;
    ir_value = ir; dr_in = din; dr_len = len; start = 1'b1;
    e.nm = nm; e.ir = eir; e.dr = edr; e.per = per; e.base = rises;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_done_timeout: got no DONE in %0d cycles, required DONE", nm, n);
      exp_q.delete();
    end
  endtask

  task automatic reset_release(input string nm);
    int base;
    @(negedge clk);
    base = rises;
    tms_n = 0;
    rst = 1'b0;
    wait_ready({nm, "_ready"}, 200);
    check({nm, "_tck_rises"}, 64'(rises - base), 64'd6);
    check({nm, "_tms_seq"}, 64'(tms_log), 64'(6'b011111));
    check({nm, "_tck_idle"}, 64'(tck), 64'd0);
  endtask

  initial begin
    int base, sh0, d3, r3, n;
    repeat (3) @(negedge clk);
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ir_out", 64'(ir_out), 64'd0);
    check("rst_dr_out", 64'(dr_out), 64'd0);

    reset_release("reset_seq");

    txn("idcode", 4'h7, 32'h0, 6'd32, 4'h1, IDCODE, 47);

    sh0 = shdr_steps;
    txn("bypass", 4'hF, 32'h1, 6'd1, 4'h1, 32'h0, 16);
    check("bypass_shdr_steps", 64'(shdr_steps - sh0), 64'd1);
    check("bypass_shdr_tms", 64'(shdr_last_tms), 64'd1);

    sh0 = shdr_steps;
    txn("ir_only", 4'h2, 32'h0, 6'd0, 4'h1, 32'h0, 10);
    check("ir_only_no_shdr", 64'(shdr_steps - sh0), 64'd0);

    txn("clamp", 4'h7, 32'h0, 6'd40, 4'h1, IDCODE, 47);
    txn("dr_len8", 4'h7, 32'h0, 6'd8, 4'h1, 32'h77, 23);

    // Divided-clock instance with a second START while busy.
    n = 0;
    while (!ready3 && n < 400) begin @(negedge clk); n++; end
    check("div3_ready", 64'(ready3), 64'd1);
    d3 = done3_cnt; r3 = rises3;
    meas3 = 1'b1; seen_fall3 = 1'b0;
    @(posedge clk); #1;
    ir_value = 4'h2; dr_len = 6'd0; start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    repeat (10) @(posedge clk);
    #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    n = 0;
    while (!ready3 && n < 400) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    meas3 = 1'b0;
    check("div3_done_count", 64'(done3_cnt - d3), 64'd1);
    check("div3_tck_rises", 64'(rises3 - r3), 64'd10);
    check("div3_high_min", 64'(hmin), 64'd3);
    check("div3_high_max", 64'(hmax), 64'd3);
    check("div3_low_min", 64'(lmin), 64'd3);
    check("div3_low_max", 64'(lmax), 64'd3);
    check("div3_ready_after", 64'(ready3), 64'd1);

    // Reset in the middle of IR_SHIFT step 2.
    wait_ready("midrst_pre", 400);
    @(posedge clk); #1;
    ir_value = 4'h7; dr_in = 32'h0; dr_len = 6'd32; start = 1'b1;
    base = rises;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while ((rises - base) < 7 && n < 200) begin @(negedge clk); n++; end
    check("midrst_reached_step", 64'(rises - base), 64'd7);
    #2 rst = 1'b1;
    #1;
    check("midrst_tck", 64'(tck), 64'd0);
    check("midrst_tms", 64'(tms), 64'd1);
    check("midrst_ir_out", 64'(ir_out), 64'd0);
    check("midrst_dr_out", 64'(dr_out), 64'd0);
    check("midrst_ready", 64'(ready), 64'd0);
    repeat (2) @(negedge clk);
    reset_release("midrst_reseq");

    txn("idcode_after_rst", 4'h7, 32'h0, 6'd32, 4'h1, IDCODE, 47);

    repeat (10) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(done_cnt), 64'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
